sm_alu_seq: RTL

Parametrised, multi-cycle successor to the 3-bit sign-magnitude ALU. It supports add, subtract, multiply and remainder on W-bit sign-magnitude operands, with a valid/ready handshake on both the input and output sides. Add and subtract complete in one cycle. Multiply and remainder run iteratively: shift-add for multiply, restoring division for remainder. The block sits between the operand/opcode front end and the result display/logging path, and keeps the zero, sign and divide-by-zero flags of the earlier ALU.

---
 rtl/sm_alu_seq.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/sm_alu_seq.sv
// Sign-magnitude add/sub/mul/rem with valid/ready handshakes; add/sub/rem-by-zero in 1 cycle, mul/rem in M+1 cycles.
// Inputs are taken only in IDLE; a result is held in DONE until out_ready, so in_ready stays low meanwhile.
module sm_alu_seq #(
    parameter int W = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [1:0]     s,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-2:0] c,
    output logic           zeroflag,
    output logic           signflag,
    output logic           divbyzeroflag
);
    localparam int M  = W - 1;
    localparam int CW = (M > 1) ? $clog2(M) : 1;
    localparam logic [CW-1:0] LAST = CW'(M - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_n;

    logic [CW-1:0]  cnt;
    logic           op_mul, sa, sb;
    logic [2*M-1:0] a_sh, acc;
    logic [M-1:0]   mq, dvd, bdiv, rem_r;
    logic [2*W-2:0] c_r;
    logic           zf_r, dbz_r;

    // Single-cycle add/sub on the live inputs; sub flips b's sign
    logic [2*M-1:0] am, bm, as_mag;
    logic           sb_eff, as_sign;
    always_comb begin
        am     = {{M{1'b0}}, a[M-1:0]};
        bm     = {{M{1'b0}}, b[M-1:0]};
        sb_eff = b[W-1] ^ s[0];
        if (a[W-1] == sb_eff) begin
            as_mag  = am + bm;
            as_sign = a[W-1];
        end else if (am >= bm) begin
            as_mag  = am - bm;
            as_sign = a[W-1];
        end else begin
            as_mag  = bm - am;
            as_sign = sb_eff;
        end
    end

    // One shift-add and one restoring-division step, evaluated every BUSY cycle
    logic [2*M-1:0] acc_nxt;
    logic [M:0]     t, bx, diff;
    logic [M-1:0]   rem_nxt;
    always_comb begin
        acc_nxt = acc + (mq[0] ? a_sh : '0);
        t       = {rem_r, dvd[M-1]};
        bx      = {1'b0, bdiv};
        diff    = t - bx;
        rem_nxt = (t >= bx) ? diff[M-1:0] : t[M-1:0];
    end

    logic           cap, step, res_en, res_sign, res_dbz;
    logic [2*M-1:0] res_mag;
    always_comb begin
        state_n  = state;
        cap      = 1'b0;
        step     = 1'b0;
        res_en   = 1'b0;
        res_mag  = '0;
        res_sign = 1'b0;
        res_dbz  = 1'b0;
        case (state)
            IDLE: if (in_valid) begin
                if (!s[1]) begin
                    res_en   = 1'b1;
                    res_mag  = as_mag;
                    res_sign = as_sign;
                    state_n  = DONE;
                end else if (s[0] && (b[M-1:0] == '0)) begin
                    res_en  = 1'b1;
                    res_dbz = 1'b1;
                    state_n = DONE;
                end else begin
                    cap     = 1'b1;
                    state_n = BUSY;
                end
            end
            BUSY: begin
                step = 1'b1;
                if (cnt == LAST) begin
                    res_en   = 1'b1;
                    res_mag  = op_mul ? acc_nxt : {{M{1'b0}}, rem_nxt};
                    res_sign = op_mul ? (sa ^ sb) : sa;
                    state_n  = DONE;
                end
            end
            DONE: if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            op_mul <= 1'b0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            a_sh   <= '0;
            acc    <= '0;
            mq     <= '0;
            dvd    <= '0;
            bdiv   <= '0;
            rem_r  <= '0;
            c_r    <= '0;
            zf_r   <= 1'b0;
            dbz_r  <= 1'b0;
        end else begin
            if (cap) begin
                cnt    <= '0;
                op_mul <= ~s[0];
                sa     <= a[W-1];
                sb     <= b[W-1];
                a_sh   <= {{M{1'b0}}, a[M-1:0]};
                acc    <= '0;
                mq     <= b[M-1:0];
                dvd    <= a[M-1:0];
                bdiv   <= b[M-1:0];
                rem_r  <= '0;
            end else if (step) begin
                cnt   <= cnt + CW'(1);
                a_sh  <= a_sh << 1;
                acc   <= acc_nxt;
                mq    <= mq >> 1;
                dvd   <= dvd << 1;
                rem_r <= rem_nxt;
            end
            // Zero magnitudes are always presented as +0
            if (res_en) begin
                c_r   <= {res_sign & (|res_mag), res_mag};
                zf_r  <= (res_mag == '0);
                dbz_r <= res_dbz;
            end
        end
    end

    assign in_ready      = (state == IDLE);
    assign out_valid     = (state == DONE);
    assign c             = c_r;
    assign zeroflag      = zf_r;
    assign signflag      = c_r[2*W-2];
    assign divbyzeroflag = dbz_r;
endmodule
